bist_fault_reporter: RTL

- BIST-side transmitter of the fault-report interface consumed by the BIRA top.
- Captures mismatches from the march comparator and buffers them in a small FIFO.
- Sends them as single-cycle fault_detect pulses carrying row, column, column flag and bank.
- Sequences test_end, honours early_term from BIRA, and stalls the march engine when its buffer nears full.

---
 rtl/bira_pkg.sv | 24 ++
 rtl/fault_fifo.sv | 63 ++++++
 rtl/bist_fault_reporter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bira_pkg.sv
// Shared types for the BIST-to-BIRA fault-report path.
package bira_pkg;

   localparam int ROW_W  = 10;
   localparam int COL_W  = 10;
   localparam int BANK_W = 2;
   localparam int FLAG_W = 8;

   typedef struct packed {
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
      logic [FLAG_W-1:0] flag;
      logic [BANK_W-1:0] bank;
   } fault_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE,
      ST_ABORT
   } reporter_state_t;

endpackage

// File: rtl/fault_fifo.sv
// Small fault buffer; head entry is read straight from the storage registers.
module fault_fifo
   import bira_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  fault_entry_t           din_i,
   output fault_entry_t           head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_nxt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fault_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   // a full buffer still takes a push when the head leaves in the same cycle
   assign do_push = push_i && (!full_o || do_pop) && !flush_i;
   assign head_o  = mem_q[rd_q];
   assign count_nxt_o = cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (flush_i)                cnt_d = '0;
      else if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
         end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/bist_fault_reporter.sv
// BIST-side fault-report transmitter: buffers comparator mismatches and
// paces them to BIRA as one-cycle fault_detect strobes.
module bist_fault_reporter
   import bira_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int GAP   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              test_start,
   input  logic              cmp_valid,
   input  logic [FLAG_W-1:0] cmp_mismatch,
   input  logic [ROW_W-1:0]  cmp_row,
   input  logic [COL_W-1:0]  cmp_col,
   input  logic [BANK_W-1:0] cmp_bank,
   input  logic              march_done,
   input  logic              early_term,
   output logic              fault_detect,
   output logic [ROW_W-1:0]  row_add_out,
   output logic [COL_W-1:0]  col_add_out,
   output logic [FLAG_W-1:0] col_flag,
   output logic [BANK_W-1:0] bank_out,
   output logic              test_end,
   output logic              aborted,
   output logic              bist_stall,
   output logic              overflow
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - 1);

   reporter_state_t   state_q;
   logic              fd_q, test_end_q, aborted_q, stall_q, overflow_q;
   logic [ROW_W-1:0]  row_q;
   logic [COL_W-1:0]  col_q;
   logic [FLAG_W-1:0] flag_q;
   logic [BANK_W-1:0] bank_q;
   logic [GW-1:0]     gap_q;

   fault_entry_t  head_w, din_w;
   logic          full_w, empty_w, active_w, push_req_w, push_w, pop_w, flush_w, drop_w;
   logic [CW-1:0] cnt_nxt_w;

   // early_term outranks both pops and pushes while a session is live
   assign active_w   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign flush_w    = active_w && early_term;
   assign pop_w      = active_w && !early_term && !empty_w && (gap_q == '0);
   assign push_req_w = (state_q == ST_RUN) && !early_term && cmp_valid && (cmp_mismatch != '0);
   assign push_w     = push_req_w && (!full_w || pop_w);
   assign drop_w     = push_req_w && full_w && !pop_w;
   assign din_w      = '{row: cmp_row, col: cmp_col, flag: cmp_mismatch, bank: cmp_bank};

   fault_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_w),
      .pop_i       (pop_w),
      .flush_i     (flush_w),
      .din_i       (din_w),
      .head_o      (head_w),
      .full_o      (full_w),
      .empty_o     (empty_w),
      .count_nxt_o (cnt_nxt_w)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         fd_q       <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         flag_q     <= '0;
         bank_q     <= '0;
         gap_q      <= '0;
         test_end_q <= 1'b0;
         aborted_q  <= 1'b0;
         stall_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         fd_q <= pop_w;
         if (pop_w) begin
            row_q  <= head_w.row;
            col_q  <= head_w.col;
            flag_q <= head_w.flag;
            bank_q <= head_w.bank;
            gap_q  <= GW'(GAP);
         end else if (gap_q != '0) begin
            gap_q <= gap_q - GW'(1);
         end
         stall_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE, ST_ABORT: begin
               if (test_start) begin
                  state_q    <= ST_RUN;
                  test_end_q <= 1'b0;
                  aborted_q  <= 1'b0;
                  overflow_q <= 1'b0;
               end
            end
            ST_RUN: begin
               if (early_term) begin
                  state_q    <= ST_ABORT;
                  test_end_q <= 1'b1;
                  aborted_q  <= 1'b1;
               end else begin
                  if (drop_w) overflow_q <= 1'b1;
                  if (march_done) state_q <= ST_DRAIN;
                  else            stall_q <= (cnt_nxt_w >= STALL_AT);
               end
            end
            ST_DRAIN: begin
               if (early_term) begin
                  state_q    <= ST_ABORT;
                  test_end_q <= 1'b1;
                  aborted_q  <= 1'b1;
               end else if (empty_w && !fd_q) begin
                  // wait out the last strobe so test_end never overlaps a report
                  state_q    <= ST_DONE;
                  test_end_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign fault_detect = fd_q;
   assign row_add_out  = row_q;
   assign col_add_out  = col_q;
   assign col_flag     = flag_q;
   assign bank_out     = bank_q;
   assign test_end     = test_end_q;
   assign aborted      = aborted_q;
   assign bist_stall   = stall_q;
   assign overflow     = overflow_q;

endmodule
